// File: rtl/isa_bus_cycle_sequencer.sv
// isa_bus_cycle_sequencer
//
// Turns a host read/write request into one timed ISA bus cycle:
// address latch, data latch, strobe, recovery, then a control-register clear.
// Handles I/O (IOR/IOW) and memory (MEMR/MEMW) cycles with programmable
// setup, strobe and recovery lengths.
//
// Optional build macro: ISA_IOCHRDY_EN
//   defined   - IOCHRDY wait states stretch the strobe, bounded by WAIT_MAX;
//               a bounded-out strobe reports timeout alongside done.
//   undefined - iochrdy is ignored, timeout is tied low, timing is fixed.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low
//   req_read       read request level (sampled in IDLE only)
//   req_write      write request level (sampled in IDLE only)
//   req_mem        1 = memory cycle, 0 = I/O cycle (latched with the request)
//   iochrdy        ISA channel ready, already synchronous to clk
//   address_load   active-low address latch enable
//   data_load      active-low data latch enable
//   ior, iow       active-low I/O strobes
//   memr, memw     active-low memory strobes
//   control_reset  active-low control-register clear
//   busy           high whenever not IDLE
//   done           one-clock pulse in the control-clear clock
//   timeout        one-clock pulse with done after a wait-state timeout

module isa_bus_cycle_sequencer #(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 1,
    parameter int WAIT_MAX        = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic req_read,
    input  logic req_write,
    input  logic req_mem,
    input  logic iochrdy,
    output logic address_load,
    output logic data_load,
    output logic ior,
    output logic iow,
    output logic memr,
    output logic memw,
    output logic control_reset,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_B = (RECOVERY_CYCLES > WAIT_MAX) ? RECOVERY_CYCLES : WAIT_MAX;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD    = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD   = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SETUP,
        STROBE,
        RECOVER,
        CTRL_RESET
    } state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             is_read, nxt_is_read;
    logic             is_mem, nxt_is_mem;
    logic             data_load_q;
    logic             read_final;
    logic             strobe_on;

`ifdef ISA_IOCHRDY_EN
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    logic [WAIT_W-1:0] waits, nxt_waits;
    logic              timed_out, nxt_timed_out;
`endif

    // Next-state / counter logic. The counter holds "clocks left minus one"
    // for the current timed state; in STROBE it parks at zero while waiting.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_is_read = is_read;
        nxt_is_mem  = is_mem;
`ifdef ISA_IOCHRDY_EN
        nxt_waits     = waits;
        nxt_timed_out = timed_out;
`endif
        unique case (state)
            IDLE: begin
                if (req_read || req_write) begin
                    nxt_state   = ADDR;
                    nxt_is_read = req_read;   // read wins when both are set
                    nxt_is_mem  = req_mem;
`ifdef ISA_IOCHRDY_EN
                    nxt_waits     = '0;
                    nxt_timed_out = 1'b0;
`endif
                end
            end
            ADDR: begin
                nxt_state = SETUP;
                nxt_cnt   = SETUP_LOAD;
            end
            SETUP: begin
                if (cnt == '0) begin
                    nxt_state = STROBE;
                    nxt_cnt   = STROBE_LOAD;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - 1'b1;
                end else begin
`ifdef ISA_IOCHRDY_EN
                    if (iochrdy) begin
                        nxt_state = RECOVER;
                        nxt_cnt   = RECOVERY_LOAD;
                    end else if (waits == WAIT_W'(WAIT_MAX)) begin
                        nxt_state     = RECOVER;
                        nxt_cnt       = RECOVERY_LOAD;
                        nxt_timed_out = 1'b1;
                    end else begin
                        nxt_waits = waits + 1'b1;
                    end
`else
                    nxt_state = RECOVER;
                    nxt_cnt   = RECOVERY_LOAD;
`endif
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    nxt_state = CTRL_RESET;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            CTRL_RESET: nxt_state = IDLE;
            default:    nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pin is clean for
    // the whole clock in which its state is active.
    always_comb begin
        strobe_on = (nxt_state == STROBE);
`ifdef ISA_IOCHRDY_EN
        // Strobe end depends on iochrdy within that clock, so the read
        // latch pulse is decoded combinationally below instead.
        read_final = 1'b0;
`else
        read_final = strobe_on && (nxt_cnt == '0) && nxt_is_read;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            is_read       <= 1'b0;
            is_mem        <= 1'b0;
            address_load  <= 1'b1;
            data_load_q   <= 1'b1;
            ior           <= 1'b1;
            iow           <= 1'b1;
            memr          <= 1'b1;
            memw          <= 1'b1;
            control_reset <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef ISA_IOCHRDY_EN
            waits         <= '0;
            timed_out     <= 1'b0;
            timeout       <= 1'b0;
`endif
        end else begin
            state         <= nxt_state;
            cnt           <= nxt_cnt;
            is_read       <= nxt_is_read;
            is_mem        <= nxt_is_mem;
            address_load  <= !(nxt_state == ADDR);
            // Write data is latched in the first SETUP clock only.
            data_load_q   <= !(((state == ADDR) && !nxt_is_read) || read_final);
            ior           <= !(strobe_on && !nxt_is_mem &&  nxt_is_read);
            iow           <= !(strobe_on && !nxt_is_mem && !nxt_is_read);
            memr          <= !(strobe_on &&  nxt_is_mem &&  nxt_is_read);
            memw          <= !(strobe_on &&  nxt_is_mem && !nxt_is_read);
            control_reset <= !(nxt_state == CTRL_RESET);
            busy          <= (nxt_state != IDLE);
            done          <= (nxt_state == CTRL_RESET);
`ifdef ISA_IOCHRDY_EN
            waits         <= nxt_waits;
            timed_out     <= nxt_timed_out;
            timeout       <= (nxt_state == CTRL_RESET) && nxt_timed_out;
`endif
        end
    end

`ifdef ISA_IOCHRDY_EN
    // Read data is latched in the clock that ends the strobe with iochrdy
    // high; a timed-out strobe ends with iochrdy low and gets no pulse.
    assign data_load = data_load_q &
                       !((state == STROBE) && is_read && (cnt == '0) && iochrdy);
`else
    logic unused_iochrdy;
    assign unused_iochrdy = iochrdy;
    assign data_load      = data_load_q;
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_isa_bus_cycle_sequencer.sv
// Directed bench for isa_bus_cycle_sequencer: a per-clock vector table for
// the default configuration plus hand sequences for the re-parameterised
// timing and (when ISA_IOCHRDY_EN is defined) IOCHRDY wait states.
// Output word order: {address_load, data_load, ior, iow, memr, memw,
//                     control_reset, busy, done, timeout}

module tb_isa_bus_cycle_sequencer;

    localparam logic [9:0] O_IDLE    = 10'b1111111_000;
    localparam logic [9:0] O_ADDR    = 10'b0111111_100;
    localparam logic [9:0] O_BUSY    = 10'b1111111_100;
    localparam logic [9:0] O_WSET    = 10'b1011111_100;
    localparam logic [9:0] O_IOW     = 10'b1110111_100;
    localparam logic [9:0] O_IOR     = 10'b1101111_100;
    localparam logic [9:0] O_IOR_DL  = 10'b1001111_100;
    localparam logic [9:0] O_MEMR    = 10'b1111011_100;
    localparam logic [9:0] O_MEMR_DL = 10'b1011011_100;
    localparam logic [9:0] O_CTRL    = 10'b1111110_110;
    localparam logic [9:0] O_CTRL_TO = 10'b1111110_111;

    logic clk = 1'b0;
    logic reset, req_read, req_write, req_mem, iochrdy;

    always #5 clk = ~clk;

    logic a1, d1, ir1, iw1, mr1, mw1, cr1, b1, dn1, t1;
    logic a2, d2, ir2, iw2, mr2, mw2, cr2, b2, dn2, t2;
    logic [9:0] o1, o2;
    assign o1 = {a1, d1, ir1, iw1, mr1, mw1, cr1, b1, dn1, t1};
    assign o2 = {a2, d2, ir2, iw2, mr2, mw2, cr2, b2, dn2, t2};

    isa_bus_cycle_sequencer dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_mem(req_mem), .iochrdy(iochrdy),
        .address_load(a1), .data_load(d1), .ior(ir1), .iow(iw1), .memr(mr1),
        .memw(mw1), .control_reset(cr1), .busy(b1), .done(dn1), .timeout(t1)
    );

    isa_bus_cycle_sequencer #(
        .SETUP_CYCLES(2), .STROBE_CYCLES(2), .RECOVERY_CYCLES(3)
    ) dut_t (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_mem(req_mem), .iochrdy(iochrdy),
        .address_load(a2), .data_load(d2), .ior(ir2), .iow(iw2), .memr(mr2),
        .memw(mw2), .control_reset(cr2), .busy(b2), .done(dn2), .timeout(t2)
    );

`ifdef ISA_IOCHRDY_EN
    logic a3, d3, ir3, iw3, mr3, mw3, cr3, b3, dn3, t3;
    logic [9:0] o3;
    assign o3 = {a3, d3, ir3, iw3, mr3, mw3, cr3, b3, dn3, t3};

    isa_bus_cycle_sequencer #(
        .WAIT_MAX(3)
    ) dut_w (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .req_mem(req_mem), .iochrdy(iochrdy),
        .address_load(a3), .data_load(d3), .ior(ir3), .iow(iw3), .memr(mr3),
        .memw(mw3), .control_reset(cr3), .busy(b3), .done(dn3), .timeout(t3)
    );
`endif

    typedef struct {
        logic       rd;
        logic       wr;
        logic       mem;
        logic       rst_n;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic add(input logic rd, input logic wr, input logic mem,
                       input logic rst_n, input logic [9:0] exp, input int n);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mem = mem; v.rst_n = rst_n; v.exp = exp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the edge, outputs sampled 1 later.
    task automatic next_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0; req_read = 1'b0; req_write = 1'b0; req_mem = 1'b0;
        next_clock();
        reset = 1'b1;
    endtask

    initial begin
        logic [9:0] e;

        // Each row: inputs held during that clock, outputs expected in it.
        add(0, 0, 0, 1, O_IDLE, 1);           // reset state
        // I/O write, request dropped after sampling
        add(0, 1, 0, 1, O_IDLE, 1);
        add(0, 0, 0, 1, O_ADDR, 1);
        add(0, 0, 0, 1, O_WSET, 1);
        add(0, 0, 0, 1, O_IOW, 4);
        add(0, 0, 0, 1, O_BUSY, 1);
        add(0, 0, 0, 1, O_CTRL, 1);
        add(0, 0, 0, 1, O_IDLE, 1);
        // memory read
        add(1, 0, 1, 1, O_IDLE, 1);
        add(0, 0, 0, 1, O_ADDR, 1);
        add(0, 0, 0, 1, O_BUSY, 1);
        add(0, 0, 0, 1, O_MEMR, 3);
        add(0, 0, 0, 1, O_MEMR_DL, 1);
        add(0, 0, 0, 1, O_BUSY, 1);
        add(0, 0, 0, 1, O_CTRL, 1);
        add(0, 0, 0, 1, O_IDLE, 1);
        // read+write held: read wins, second cycle restarts at c10
        add(1, 1, 0, 1, O_IDLE, 1);
        add(1, 1, 0, 1, O_ADDR, 1);
        add(1, 1, 0, 1, O_BUSY, 1);
        add(1, 1, 0, 1, O_IOR, 3);
        add(1, 1, 0, 1, O_IOR_DL, 1);
        add(1, 1, 0, 1, O_BUSY, 1);
        add(1, 1, 0, 1, O_CTRL, 1);
        add(1, 1, 0, 1, O_IDLE, 1);
        add(1, 1, 0, 0, O_ADDR, 1);           // c10, reset applied here
        add(0, 0, 0, 1, O_IDLE, 2);
        // write aborted by reset in c4: no control_reset/done afterwards
        add(0, 1, 0, 1, O_IDLE, 1);
        add(0, 0, 0, 1, O_ADDR, 1);
        add(0, 0, 0, 1, O_WSET, 1);
        add(0, 0, 0, 1, O_IOW, 1);
        add(0, 0, 0, 0, O_IOW, 1);
        add(0, 0, 0, 1, O_IDLE, 4);

        reset = 1'b0; req_read = 1'b0; req_write = 1'b0; req_mem = 1'b0;
        iochrdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            req_read  = vecs[i].rd;
            req_write = vecs[i].wr;
            req_mem   = vecs[i].mem;
            reset     = vecs[i].rst_n;
            #1;
            check($sformatf("vec%0d", i), o1, vecs[i].exp);
            next_clock();
        end

        // SETUP=2, STROBE=2, RECOVERY=3 I/O write
        pulse_reset();
        for (int k = 0; k <= 10; k++) begin
            req_write = (k == 0);
            #1;
            e = O_IDLE;
            if (k == 1)                e = O_ADDR;
            else if (k == 2)           e = O_WSET;
            else if (k == 3)           e = O_BUSY;
            else if (k == 4 || k == 5) e = O_IOW;
            else if (k >= 6 && k <= 8) e = O_BUSY;
            else if (k == 9)           e = O_CTRL;
            check($sformatf("timing_c%0d", k), o2, e);
            next_clock();
        end

`ifdef ISA_IOCHRDY_EN
        // I/O read stretched by iochrdy low in c3..c10
        pulse_reset();
        for (int k = 0; k <= 14; k++) begin
            req_read = (k == 0);
            iochrdy  = !(k >= 3 && k <= 10);
            #1;
            e = O_IDLE;
            if (k == 1)                 e = O_ADDR;
            else if (k == 2)            e = O_BUSY;
            else if (k >= 3 && k <= 10) e = O_IOR;
            else if (k == 11)           e = O_IOR_DL;
            else if (k == 12)           e = O_BUSY;
            else if (k == 13)           e = O_CTRL;
            check($sformatf("wait_c%0d", k), o1, e);
            next_clock();
        end

        // WAIT_MAX=3 with iochrdy stuck low: timeout path
        pulse_reset();
        iochrdy = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            req_read = (k == 0);
            #1;
            e = O_IDLE;
            if (k == 1)                e = O_ADDR;
            else if (k == 2)           e = O_BUSY;
            else if (k >= 3 && k <= 9) e = O_IOR;
            else if (k == 10)          e = O_BUSY;
            else if (k == 11)          e = O_CTRL_TO;
            check($sformatf("tmo_c%0d", k), o3, e);
            next_clock();
        end
        iochrdy = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
